// File: rtl/jet_topn_sorter.sv
// Keeps the NJETS highest-pT jets of each event sorted and streams them out on the last-of-event word.
// Optional macro JET_HT_SUM_EN adds scalar HT / jet-count accumulators and a trailing HT summary word.
module jet_topn_sorter #(
  parameter int          NJETS  = 4,
  parameter logic [11:0] PT_MIN = 12'd1
) (
  input  logic        s_clk,
  input  logic        reset,
  input  logic [31:0] jet_in,
  input  logic        vld_in,
  output logic        rdy_out,
  output logic [31:0] dout,
  output logic        vld_out,
  input  logic        rdy_in
);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
`ifdef JET_HT_SUM_EN
  localparam logic [1:0] ST_HT      = 2'd2;
  localparam logic       SLOT_LAST  = 1'b0;
`else
  localparam logic       SLOT_LAST  = 1'b1;
`endif
  localparam logic [2:0] LAST_IDX   = 3'(NJETS - 1);

  logic [1:0]       state;
  logic [2:0]       idx;
  logic [2:0]       nxt_idx;
  logic [31:0]      slot     [NJETS];
  logic [31:0]      upd_slot [NJETS];
  logic [NJETS-1:0] slot_vld;
  logic [NJETS-1:0] upd_vld;
  logic [3:0]       ins_pos;
  logic [11:0]      in_pt;
  logic [31:0]      new_word;
  logic [31:0]      first_word;
  logic [31:0]      next_word;
  logic             accept;
  logic             qualify;
  logic             evt_done;

`ifdef JET_HT_SUM_EN
  logic [15:0] ht;
  logic [15:0] ht_next;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic [16:0] ht_sum;
`endif

  // Occupied entries with pT >= incoming form a prefix, so their count is
  // the insertion point; this keeps earlier arrivals ahead on ties.
  always_comb begin
    in_pt    = jet_in[31:20];
    accept   = vld_in && rdy_out && (state == ST_COLLECT);
    qualify  = accept && (in_pt >= PT_MIN);
    new_word = {jet_in[31:1], 1'b0};
    ins_pos  = 4'd0;
    for (int i = 0; i < NJETS; i++) begin
      if (slot_vld[i] && (slot[i][31:20] >= in_pt)) begin
        ins_pos = ins_pos + 4'd1;
      end
    end
    upd_slot = slot;
    upd_vld  = slot_vld;
    if (qualify) begin
      if (ins_pos == 4'd0) begin
        upd_slot[0] = new_word;
        upd_vld[0]  = 1'b1;
      end
      for (int i = 1; i < NJETS; i++) begin
        if (i[3:0] == ins_pos) begin
          upd_slot[i] = new_word;
          upd_vld[i]  = 1'b1;
        end else if (i[3:0] > ins_pos) begin
          upd_slot[i] = slot[i-1];
          upd_vld[i]  = slot_vld[i-1];
        end
      end
    end
  end

  always_comb begin
    first_word = upd_slot[0];
    if (LAST_IDX == 3'd0) begin
      first_word[0] = SLOT_LAST;
    end
    nxt_idx   = idx + 3'd1;
    next_word = '0;
    for (int i = 0; i < NJETS; i++) begin
      if (i[2:0] == nxt_idx) begin
        next_word = slot[i];
      end
    end
    if (nxt_idx == LAST_IDX) begin
      next_word[0] = SLOT_LAST;
    end
`ifdef JET_HT_SUM_EN
    evt_done = (state == ST_HT) && rdy_in;
`else
    evt_done = (state == ST_FLUSH) && rdy_in && (idx == LAST_IDX);
`endif
  end

`ifdef JET_HT_SUM_EN
  always_comb begin
    ht_sum   = {1'b0, ht} + {5'd0, in_pt};
    ht_next  = ht_sum[16] ? 16'hFFFF : ht_sum[15:0];
    cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  end

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      ht  <= '0;
      cnt <= '0;
    end else if (evt_done) begin
      ht  <= '0;
      cnt <= '0;
    end else if (qualify) begin
      ht  <= ht_next;
      cnt <= cnt_next;
    end
  end
`endif

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NJETS; i++) begin
        slot[i] <= '0;
      end
      slot_vld <= '0;
    end else if (evt_done) begin
      for (int i = 0; i < NJETS; i++) begin
        slot[i] <= '0;
      end
      slot_vld <= '0;
    end else if (qualify) begin
      for (int i = 0; i < NJETS; i++) begin
        slot[i] <= upd_slot[i];
      end
      slot_vld <= upd_vld;
    end
  end

  // The first flush word is loaded from the post-insertion array so the
  // last jet of the event is already in place when vld_out rises.
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_COLLECT;
      idx     <= '0;
      rdy_out <= 1'b1;
      vld_out <= 1'b0;
      dout    <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (accept && jet_in[0]) begin
            state   <= ST_FLUSH;
            idx     <= '0;
            rdy_out <= 1'b0;
            vld_out <= 1'b1;
            dout    <= first_word;
          end
        end
        ST_FLUSH: begin
          if (rdy_in) begin
            if (idx == LAST_IDX) begin
`ifdef JET_HT_SUM_EN
              state <= ST_HT;
              dout  <= {ht, cnt, 7'b0, 1'b1};
`else
              state   <= ST_COLLECT;
              rdy_out <= 1'b1;
              vld_out <= 1'b0;
              dout    <= '0;
`endif
            end else begin
              idx  <= nxt_idx;
              dout <= next_word;
            end
          end
        end
`ifdef JET_HT_SUM_EN
        ST_HT: begin
          if (rdy_in) begin
            state   <= ST_COLLECT;
            rdy_out <= 1'b1;
            vld_out <= 1'b0;
            dout    <= '0;
          end
        end
`endif
        default: begin
          state   <= ST_COLLECT;
          rdy_out <= 1'b1;
          vld_out <= 1'b0;
          dout    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jet_topn_sorter.sv
// Scoreboard bench for jet_topn_sorter: two instances (PT_MIN 1 and 20) see the same jet stream;
// a reference model sorts each event's accepted jets and queues the expected output pairs.
module tb_jet_topn_sorter;

  localparam int NJETS = 4;
`ifdef JET_HT_SUM_EN
  localparam bit HT_EN = 1'b1;
`else
  localparam bit HT_EN = 1'b0;
`endif
  localparam int NWORDS = NJETS + (HT_EN ? 1 : 0);

  logic        s_clk = 1'b0;
  logic        reset;
  logic [31:0] jet_in;
  logic        vld_in;
  logic        rdy_in;
  logic        rdy_out_a, rdy_out_b;
  logic        vld_out_a, vld_out_b;
  logic [31:0] dout_a, dout_b;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          bp_mode = 0;
  logic [63:0] exp_q [$];
  logic [31:0] ev_q [$];

  jet_topn_sorter #(.NJETS(NJETS), .PT_MIN(12'd1)) dut_a (
    .s_clk(s_clk), .reset(reset), .jet_in(jet_in), .vld_in(vld_in), .rdy_out(rdy_out_a),
    .dout(dout_a), .vld_out(vld_out_a), .rdy_in(rdy_in)
  );

  jet_topn_sorter #(.NJETS(NJETS), .PT_MIN(12'd20)) dut_b (
    .s_clk(s_clk), .reset(reset), .jet_in(jet_in), .vld_in(vld_in), .rdy_out(rdy_out_b),
    .dout(dout_b), .vld_out(vld_out_b), .rdy_in(rdy_in)
  );

  always #5 s_clk = ~s_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: stable descending sort of qualifying jets, top NJETS, zero padded.
  task automatic build_expected();
    logic [31:0] wd [2][NWORDS];
    logic [31:0] srt [$];
    int pmin, sum, cnt, pt, pos;
    for (int d = 0; d < 2; d++) begin
      pmin = (d == 0) ? 1 : 20;
      sum = 0;
      cnt = 0;
      srt.delete();
      foreach (ev_q[k]) begin
        pt = int'(ev_q[k][31:20]);
        if (pt >= pmin) begin
          pos = 0;
          while (pos < srt.size() && int'(srt[pos][31:20]) >= pt) pos++;
          srt.insert(pos, {ev_q[k][31:1], 1'b0});
          sum += pt;
          cnt++;
        end
      end
      for (int j = 0; j < NJETS; j++) begin
        wd[d][j] = (j < srt.size()) ? srt[j] : 32'h0;
      end
      if (HT_EN) begin
        wd[d][NWORDS-1] = {(sum > 65535) ? 16'hFFFF : 16'(sum), (cnt > 255) ? 8'hFF : 8'(cnt), 8'h01};
      end else begin
        wd[d][NWORDS-1][0] = 1'b1;
      end
    end
    for (int j = 0; j < NWORDS; j++) begin
      exp_q.push_back({wd[0][j], wd[1][j]});
    end
    ev_q.delete();
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    int  n;
    bit  ok;
    jet_in = w;
    vld_in = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 500) begin
      @(negedge s_clk);
      if (rdy_out_a) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: rdy_out %b, required 1", rdy_out_a);
    end
    @(posedge s_clk);
    #1;
    vld_in = 1'b0;
    if (ok) begin
      ev_q.push_back(w);
      if (w[0]) build_expected();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge s_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  // rdy_in has a single driver; the main sequence selects its mode.
  initial begin
    rdy_in = 1'b1;
    forever begin
      @(posedge s_clk);
      #1;
      case (bp_mode)
        1:       rdy_in = ($urandom_range(0, 3) != 0);
        2:       rdy_in = 1'b0;
        default: rdy_in = 1'b1;
      endcase
    end
  end

  // Monitor: pops one expected pair per output transfer and checks hold-while-stalled.
  initial begin : checkOutput
    logic [31:0] held;
    logic [63:0] e;
    bit          stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge s_clk);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_vld", {31'b0, vld_out_a}, 32'd1);
          check("hold_dout", dout_a, held);
        end
        if (vld_out_a && rdy_in) begin
          check("vld_b", {31'b0, vld_out_b}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word: got %h, required no output", dout_a);
          end else begin
            e = exp_q.pop_front();
            check("out_a", dout_a, e[63:32]);
            check("out_b", dout_b, e[31:0]);
            pops++;
          end
        end
        stalled = vld_out_a && !rdy_in;
        held    = dout_a;
      end
    end
  end

  initial begin
    int base, n, cnt_j;
    logic [11:0] pt;
    reset  = 1'b0;
    jet_in = '0;
    vld_in = 1'b0;
    repeat (3) @(posedge s_clk);
    #1;
    check("rst_rdy_a", {31'b0, rdy_out_a}, 32'd1);
    check("rst_rdy_b", {31'b0, rdy_out_b}, 32'd1);
    check("rst_vld_a", {31'b0, vld_out_a}, 32'd0);
    check("rst_vld_b", {31'b0, vld_out_b}, 32'd0);
    check("rst_dout_a", dout_a, 32'h0);
    check("rst_dout_b", dout_b, 32'h0);
    @(negedge s_clk);
    reset = 1'b1;
    @(posedge s_clk);
    #1;

    $display("[TB] sort event");
    applyStimulus({12'd30, 20'h0});
    applyStimulus({12'd80, 20'h0});
    applyStimulus({12'd10, 20'h0});
    applyStimulus({12'd50, 20'h0});
    applyStimulus({12'd60, 20'h1});
    drain();

    $display("[TB] tie and threshold event");
    applyStimulus({12'd40, 5'd3, 5'd7, 5'd2, 5'd0});
    applyStimulus({12'd40, 5'd9, 5'd1, 5'd4, 5'd0});
    applyStimulus({12'd15, 5'd5, 5'd5, 5'd5, 5'd1});
    drain();

    $display("[TB] saturation event");
    for (int i = 0; i < 20; i++) begin
      applyStimulus({12'hFFF, 19'($urandom), (i == 19) ? 1'b1 : 1'b0});
    end
    drain();

    $display("[TB] empty event");
    applyStimulus(32'h0000_0001);
    drain();

    $display("[TB] backpressure during flush");
    applyStimulus({12'd100, 20'h0});
    applyStimulus({12'd200, 20'h0});
    bp_mode = 2;
    @(posedge s_clk);
    #2;
    applyStimulus({12'd150, 20'h1});
    repeat (5) @(negedge s_clk);
    check("bp_rdy_out", {31'b0, rdy_out_a}, 32'd0);
    check("bp_vld_out", {31'b0, vld_out_a}, 32'd1);
    bp_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge s_clk);
      if (exp_q.size() != 0) check("bp_rdy_low", {31'b0, rdy_out_a}, 32'd0);
      n++;
    end
    @(negedge s_clk);
    check("bp_rdy_back", {31'b0, rdy_out_a}, 32'd1);
    check("bp_rdy_back_b", {31'b0, rdy_out_b}, 32'd1);

    $display("[TB] reset mid-flush");
    applyStimulus({12'd300, 20'h0});
    applyStimulus({12'd310, 20'h0});
    base = pops;
    applyStimulus({12'd320, 20'h1});
    n = 0;
    while (pops < base + 2 && n < 100) begin
      @(posedge s_clk);
      n++;
    end
    if (pops < base + 2) begin
      checks++;
      errors++;
      $display("[TB] FAIL flush_timeout: %0d words seen, required 2", pops - base);
    end
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_vld_a", {31'b0, vld_out_a}, 32'd0);
    check("mid_rst_rdy_a", {31'b0, rdy_out_a}, 32'd1);
    check("mid_rst_dout_a", dout_a, 32'h0);
    check("mid_rst_vld_b", {31'b0, vld_out_b}, 32'd0);
    check("mid_rst_rdy_b", {31'b0, rdy_out_b}, 32'd1);
    exp_q.delete();
    ev_q.delete();
    repeat (2) @(posedge s_clk);
    @(negedge s_clk);
    reset = 1'b1;
    @(posedge s_clk);
    #1;
    applyStimulus({12'd25, 20'h0});
    applyStimulus({12'd70, 20'h1});
    drain();

    $display("[TB] random events");
    bp_mode = 1;
    for (int e = 0; e < 8; e++) begin
      cnt_j = $urandom_range(1, 10);
      for (int k = 0; k < cnt_j; k++) begin
        case ($urandom_range(0, 3))
          0:       pt = 12'($urandom_range(0, 4095));
          1:       pt = 12'd40;
          2:       pt = 12'd15;
          default: pt = 12'($urandom_range(0, 30));
        endcase
        repeat ($urandom_range(0, 2)) @(posedge s_clk);
        #1;
        applyStimulus({pt, 19'($urandom), (k == cnt_j - 1) ? 1'b1 : 1'b0});
      end
      drain();
    end
    bp_mode = 0;
    repeat (4) @(posedge s_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jet_topn_sorter.md
# jet_topn_sorter

Downstream stage of the jet-finding top level: consumes the 32-bit jet stream (`dout`/`vld_out`, back-pressured through its `rdy_in`), keeps the NJETS highest-pT jets of each event in a sorted register array, and accumulates scalar HT. On the event's last word it emits the sorted list, optionally followed by an HT summary word, to the readout with a valid/ready handshake.

## Interface
- `NJETS`, 4: number of jet slots kept and emitted per event (range 1–8).
- `PT_MIN`, 12'd1: minimum pT for a jet to be sorted and counted in HT.
- `s_clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `jet_in`  in  32  jet word from jet finder. Bits [31:20] are pT (unsigned). Bits [19:15] are eta bin. Bits [14:10] are phi bin. Bits [9:5] are track count. Bits [4:1] are reserved. Bit [0] is last-of-event.
- `vld_in`  in  1  `jet_in` valid.
- `rdy_out`  out  1  able to accept `jet_in`; drives the jet finder's `rdy_in`.
- `dout`  out  32  sorted jet word or HT word.
- `vld_out`  out  1  `dout` valid.
- `rdy_in`  in  1  downstream ready.

## Operation
- A transfer happens in a cycle where the valid and the matching ready are both high at the `s_clk` edge.
- States:
  - COLLECT (reset state): `rdy_out`=1.
  - FLUSH: emits slots 0..NJETS-1.
  - HT: present only with the macro enabled.
- COLLECT, on accepted word with pT ≥ PT_MIN:
  - Insert the word into slot array `slot[0..NJETS-1]`, descending by pT.
  - On equal pT, the incoming jet goes after existing equal entries, so earlier arrival wins.
  - The entry in `slot[NJETS-1]` falls off when the array is full.
  - HT += pT, saturating at 16'hFFFF.
  - Jet count += 1, saturating at 8'hFF.
- COLLECT, on accepted word with pT < PT_MIN: no insertion and no HT change. The bit-0 check still applies.
- Bit 0 is set on an accepted word: the word is processed as above in the same cycle, then the next state is FLUSH with slot index 0.
- FLUSH:
  - `dout` = `slot[idx]`, with bit 0 forced to 0. Empty slots read as 32'h0.
  - Advance `idx` on each output transfer.
  - After slot NJETS-1 transfers, go to HT (macro enabled) or return to COLLECT.
  - Without the macro, the word from `slot[NJETS-1]` carries bit 0 = 1.
- HT state:
  - `dout` = {HT[15:0], count[7:0], 7'b0, 1'b1}.
  - On transfer, go to COLLECT.
- On return to COLLECT: slots, HT and count are cleared in the same edge.
- `rdy_out` is 0 in FLUSH and HT. Upstream words are held by the upstream stage, never dropped.
- Reset asserted mid-event or mid-flush: all state is cleared immediately and asynchronously. Partial events are discarded.

## Timing
- Reset values: `rdy_out`=1, `vld_out`=0, `dout`=32'h0, state=COLLECT, slots/HT/count=0.
- `rdy_out` is a registered function of state only. It has no combinational path from `vld_in` or `rdy_in`.
- `dout`/`vld_out` are registered.
- Last word accepted at edge N:
  - `vld_out`=1 with `slot[0]` (including that last jet if it qualifies) from edge N+1.
  - With `rdy_in` held high, one output word per cycle. `vld_out` drops after the final word.
  - `rdy_out` returns to 1 in the cycle after the final output transfer.
  - Event turnaround is NJETS(+1) cycles.
- `rdy_in`=0: `dout`/`vld_out` hold stable, with no change until the transfer.
- Insertion is single-cycle. One jet per cycle is sustained in COLLECT.
- An event of a single word (last flag set, pT 0) still produces a full flush of zero slots, plus an HT word with HT=0 and count=0.

## Configuration
- `JET_HT_SUM_EN` defined:
  - HT/count accumulators and the HT state are built.
  - Each event outputs NJETS+1 words, and the HT word carries the last flag.
- `JET_HT_SUM_EN` undefined:
  - No accumulators and no HT state.
  - Each event outputs NJETS words, and `slot[NJETS-1]` carries the last flag.

## Test plan
- **Sort:** NJETS=4, rdy_in=1; feed pT 30, 80, 10, 50, 60 (last on 60). Required: `dout` pT sequence 80, 60, 50, 30. With the macro, the HT word is {16'd230, 8'd5, 7'b0, 1'b1}.
- **Tie and threshold:** PT_MIN=20; feed A(pT 40), B(pT 40), C(pT 15, last). Required: A, B, 0, 0. HT=80, count=2.
- **Backpressure:** rdy_in low for 5 cycles during FLUSH. Required:
  - `dout` stable while rdy_in is low and no words are lost.
  - `rdy_out` stays 0 until the final output transfer, then returns to 1 the next cycle.
- **Saturation:** 20 jets of pT 4095. Required: HT=16'hFFFF, count=20, slots all pT 4095.
- **Reset mid-flush:** assert reset after the 2nd output word. Required: `vld_out`=0 and `rdy_out`=1 immediately. The next event's output contains no stale jets.
- **Empty event:** a single word 32'h00000001. Required: 4 zero words, then HT word 32'h00000001. Without the macro: zero words, with bit 0 set on the 4th.
